gemm_arb_2x2: RTL

GEMM_ARB_2X2 -- requirements
Module: gemm_arb_2x2

---
 rtl/gemm_arb_pkg.sv | 26 ++
 rtl/gemm_arb_fifo.sv | 60 ++++++
 rtl/gemm_arb_2x2.sv | 109 ++++++++++
 3 files changed

// File: rtl/gemm_arb_pkg.sv
// Shared widths, result payload type and matrix element packing for the 2x2 GEMM arbiter.
package gemm_arb_pkg;

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned ELEM_W = 32;
    localparam int unsigned MAT_W  = 128;
    localparam int unsigned ID_W   = 1;

    // Element slot within a packed 128-bit matrix: element k sits at [k*ELEM_W +: ELEM_W]
    localparam int unsigned M00_IDX = 0;
    localparam int unsigned M01_IDX = 1;
    localparam int unsigned M10_IDX = 2;
    localparam int unsigned M11_IDX = 3;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [MAT_W-1:0] data;
    } resp_t;

    localparam int unsigned RESP_W = $bits(resp_t);

    function automatic logic [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] m, input int unsigned idx);
        return m[idx*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/gemm_arb_fifo.sv
// Result FIFO: registered storage, head visible the cycle after the first push.
module gemm_arb_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 129
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        valid   = (count != '0);
        do_push = push && !full;
        do_pop  = pop && valid;
        rd_data = valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            a_no_overflow: assert (!(push && full));
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gemm_arb_2x2.sv
// Two-requester round-robin front end for an external fixed-latency 2x2 GEMM pipeline,
// with credit-based issue and an in-order result FIFO.
module gemm_arb_2x2
    import gemm_arb_pkg::*;
#(
    parameter int unsigned LAT        = 6,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [MAT_W-1:0] req_a0,
    input  logic [MAT_W-1:0] req_b0,
    input  logic [MAT_W-1:0] req_a1,
    input  logic [MAT_W-1:0] req_b1,
    output logic [MAT_W-1:0] dp_a,
    output logic [MAT_W-1:0] dp_b,
    input  logic [MAT_W-1:0] dp_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [MAT_W-1:0] resp_data,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic              rr;
    logic [LAT-1:0]    trk_valid;
    logic [LAT-1:0]    trk_id;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              credit;
    logic              grant0;
    logic              grant1;
    logic              issue;
    logic              issue_id;
    logic              mature;
    resp_t             push_entry;
    resp_t             head;
    logic [RESP_W-1:0] head_bits;

    // Credit covers every job issued but not yet popped; a same-cycle pop is not counted back
    always_comb begin
        inflight  = CNT_W'($countones(trk_valid));
        credit    = rst && ((SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
        grant0    = credit && req_valid[0] && (!req_valid[1] || !rr);
        grant1    = credit && req_valid[1] && (!req_valid[0] ||  rr);
        req_ready = {grant1, grant0};
        issue     = grant0 || grant1;
        issue_id  = grant1;
        dp_a      = '0;
        dp_b      = '0;
        if (grant0) begin
            dp_a = req_a0;
            dp_b = req_b0;
        end else if (grant1) begin
            dp_a = req_a1;
            dp_b = req_b1;
        end
    end

    // Round-robin pointer prefers the requester not served last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= 1'b0;
        end else if (issue) begin
            rr <= ~issue_id;
        end
    end

    // Tracker: bit LAT-1 lines up with dp_out for the job issued LAT cycles ago
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_valid <= '0;
            trk_id    <= '0;
        end else begin
            trk_valid <= LAT'({trk_valid, issue});
            trk_id    <= LAT'({trk_id, issue_id});
        end
    end

    always_comb begin
        mature          = trk_valid[LAT-1];
        push_entry.id   = trk_id[LAT-1];
        push_entry.data = dp_out;
        head            = resp_t'(head_bits);
        resp_id         = head.id;
        resp_data       = head.data;
        busy            = (inflight != '0) || (fifo_count != '0);
    end

    gemm_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RESP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mature),
        .push_data (push_entry),
        .pop       (resp_valid && resp_ready),
        .valid     (resp_valid),
        .rd_data   (head_bits),
        .count     (fifo_count)
    );

endmodule
